// File: rtl/crg_pkg.sv
// Shared clock/reset-generator definitions: sequencer state type and default sizing.
// Used by rst_seq, rst_seq_if and the bench.
package crg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RELEASE = 2'd1,
    DONE    = 2'd2
  } rst_seq_state_e;

  localparam int unsigned DEF_NUM_DOMAINS = 4;
  localparam int unsigned DEF_LOCK_CYCLES = 8;
  localparam int unsigned DEF_STEP_CYCLES = 4;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_seq_if.sv
// Lock/request inputs and sequenced reset outputs of the reset release sequencer.
// The master side is the upstream clock logic; the slave side is rst_seq.
interface rst_seq_if #(
  parameter int unsigned NUM_DOMAINS = crg_pkg::DEF_NUM_DOMAINS
);
  logic                   lock_i;
  logic                   sw_rst_i;
  logic [NUM_DOMAINS-1:0] rst_no;
  logic                   done_o;

  modport master (output lock_i, sw_rst_i, input  rst_no, done_o);
  modport slave  (input  lock_i, sw_rst_i, output rst_no, done_o);
endinterface

// File: rtl/rst_seq_timer.sv
// Enable/clear up-counter with a terminal-count flag against a run-time limit.
// Shared by the lock qualification count and the inter-release step count.
module rst_seq_timer #(
  parameter  int unsigned MAX_COUNT = 8,
  localparam int unsigned W         = $clog2(MAX_COUNT + 1)
) (
  input  logic         clk_i,
  input  logic         arst_ni,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_last,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  // NOTE: state flops use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_tc = (r_cnt == i_last);

endmodule

// File: rtl/rst_seq.sv
// Reset release sequencer: qualifies lock, then releases domain resets one by one.
// Define CRG_RST_SEQ_SYNC_EN to add 2-flop synchronizers on lock_i and sw_rst_i.
module rst_seq
  import crg_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS = DEF_NUM_DOMAINS,
  parameter int unsigned LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter int unsigned STEP_CYCLES = DEF_STEP_CYCLES
) (
  input  logic     clk_i,
  input  logic     arst_ni,
  rst_seq_if.slave bus
);

  localparam int unsigned CW = $clog2(max_u(LOCK_CYCLES, STEP_CYCLES) + 1);
  localparam int unsigned IW = $clog2(NUM_DOMAINS + 1);

  logic w_lock;
  logic w_sw_rst;

`ifdef CRG_RST_SEQ_SYNC_EN
  logic [1:0] r_lock_sync;
  logic [1:0] r_sw_sync;

  // NOTE: async reset belongs on control/state flops only; these are plain registers, not memories.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_lock_sync <= '0;
      r_sw_sync   <= '0;
    end else begin
      r_lock_sync <= {r_lock_sync[0], bus.lock_i};
      r_sw_sync   <= {r_sw_sync[0], bus.sw_rst_i};
    end
  end

  assign w_lock   = r_lock_sync[1];
  assign w_sw_rst = r_sw_sync[1];
`else
  assign w_lock   = bus.lock_i;
  assign w_sw_rst = bus.sw_rst_i;
`endif

  rst_seq_state_e         r_state;
  logic [NUM_DOMAINS-1:0] r_rst_n;
  logic                   r_done;
  logic [IW-1:0]          r_idx;

  logic          w_good;
  logic          w_tc;
  logic          w_en;
  logic          w_clr;
  logic [CW-1:0] w_last;

  // A bad cycle clears the lock count in IDLE and aborts in RELEASE/DONE.
  assign w_good = w_lock & ~w_sw_rst;
  assign w_last = (r_state == IDLE) ? CW'(LOCK_CYCLES - 1) : CW'(STEP_CYCLES - 1);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_en  = 1'b0;
    w_clr = 1'b0;
    case (r_state)
      IDLE, RELEASE: begin
        if (!w_good || w_tc) w_clr = 1'b1;
        else                 w_en  = 1'b1;
      end
      default: w_clr = 1'b1;
    endcase
  end

  rst_seq_timer #(
    .MAX_COUNT (max_u(LOCK_CYCLES, STEP_CYCLES))
  ) u_timer (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .i_en    (w_en),
    .i_clr   (w_clr),
    .i_last  (w_last),
    .o_tc    (w_tc)
  );

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_state <= IDLE;
      r_rst_n <= '0;
      r_done  <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_good && w_tc) begin
            r_state <= RELEASE;
            r_idx   <= '0;
          end
        end
        RELEASE: begin
          // Abort outranks a step completion in the same cycle.
          if (!w_good) begin
            r_state <= IDLE;
            r_rst_n <= '0;
            r_done  <= 1'b0;
            r_idx   <= '0;
          end else if (w_tc) begin
            for (int k = 0; k < int'(NUM_DOMAINS); k++) begin
              if (r_idx == IW'(k)) r_rst_n[k] <= 1'b1;
            end
            r_idx <= r_idx + IW'(1);
            if (r_idx == IW'(NUM_DOMAINS - 1)) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          if (!w_good) begin
            r_state <= IDLE;
            r_rst_n <= '0;
            r_done  <= 1'b0;
            r_idx   <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_rst_n <= '0;
          r_done  <= 1'b0;
          r_idx   <= '0;
        end
      endcase
    end
  end

  assign bus.rst_no = r_rst_n;
  assign bus.done_o = r_done;

endmodule
